// File: rtl/branch_prediction_checker.sv
// Branch prediction checker: holds in-flight predictions in a circular queue,
// compares each against its resolution, trains the predictor, and redirects
// fetch on a mispredict.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// NORMAL   | accepting pushes and resolutions
// REDIRECT | one-cycle fetch redirect after a mispredict; queue is flushed
module branch_prediction_checker #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 26
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push_valid,
   input  logic [ADDR_WIDTH-1:0] i_push_pc,
   input  logic                  i_push_prediction,
   input  logic [ADDR_WIDTH-1:0] i_push_target,
   output logic                  o_full,
   output logic                  o_empty,
   input  logic                  i_res_valid,
   input  logic                  i_res_outcome,
   input  logic [ADDR_WIDTH-1:0] i_res_target,
   output logic                  o_redirect_valid,
   output logic [ADDR_WIDTH-1:0] o_redirect_pc,
   output logic                  o_fb_valid,
   output logic [ADDR_WIDTH-1:0] o_fb_pc,
   output logic                  o_fb_prediction,
   output logic                  o_fb_outcome,
   output logic [ADDR_WIDTH-1:0] o_fb_target,
   output logic [15:0]           o_mispredict_count,
   output logic                  o_error
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic {
      NORMAL   = 1'b0,
      REDIRECT = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
   logic                  mem_pred [DEPTH];
   logic [ADDR_WIDTH-1:0] mem_tgt  [DEPTH];

   logic [PW:0] wr_ptr, rd_ptr;

   logic                  full, empty, normal;
   logic                  pop, push_ok, mispredict, flush, proto_err;
   logic [ADDR_WIDTH-1:0] head_pc, head_tgt, corrected;
   logic                  head_pred;

   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  fb_valid, fb_pred, fb_out;
   logic [ADDR_WIDTH-1:0] fb_pc, fb_tgt;
   logic [15:0]           mispredict_cnt;
   logic                  error;

   // Queue status, head lookup and accept/pop/mispredict decisions
   always_comb begin
      full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
      empty      = (wr_ptr == rd_ptr);
      normal     = (state == NORMAL);
      head_pc    = mem_pc[rd_ptr[PW-1:0]];
      head_pred  = mem_pred[rd_ptr[PW-1:0]];
      head_tgt   = mem_tgt[rd_ptr[PW-1:0]];
      pop        = normal & i_res_valid & ~empty;
      // A full queue always has a head, so a same-cycle resolution frees a slot.
      push_ok    = normal & i_push_valid & (~full | i_res_valid);
      mispredict = (i_res_outcome != head_pred) |
                   (i_res_outcome & head_pred & (i_res_target != head_tgt));
      flush      = pop & mispredict;
      proto_err  = normal & ((i_push_valid & full & ~i_res_valid) | (i_res_valid & empty));
      corrected  = i_res_outcome ? i_res_target : (head_pc + ADDR_WIDTH'(8));
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         NORMAL:   if (flush) state_nxt = REDIRECT;
         REDIRECT: state_nxt = NORMAL;
         default:  state_nxt = NORMAL;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= NORMAL;
      else     state <= state_nxt;
   end

   // Queue pointers; a mispredict flushes every younger entry
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)     rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   // Entry storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem_pc[wr_ptr[PW-1:0]]   <= i_push_pc;
         mem_pred[wr_ptr[PW-1:0]] <= i_push_prediction;
         mem_tgt[wr_ptr[PW-1:0]]  <= i_push_target;
      end
   end

   // Training feedback, one cycle after every pop
   always_ff @(posedge clk) begin
      if (rst) begin
         fb_valid <= 1'b0;
         fb_pc    <= '0;
         fb_pred  <= 1'b0;
         fb_out   <= 1'b0;
         fb_tgt   <= '0;
      end else begin
         fb_valid <= pop;
         if (pop) begin
            fb_pc   <= head_pc;
            fb_pred <= head_pred;
            fb_out  <= i_res_outcome;
            fb_tgt  <= i_res_target;
         end
      end
   end

   // Corrected fetch PC, held between redirects
   always_ff @(posedge clk) begin
      if (rst)        redirect_pc <= '0;
      else if (flush) redirect_pc <= corrected;
   end

   // Saturating mispredict counter
   always_ff @(posedge clk) begin
      if (rst)                                   mispredict_cnt <= '0;
      else if (flush && mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
   end

   // Sticky protocol error
   always_ff @(posedge clk) begin
      if (rst)            error <= 1'b0;
      else if (proto_err) error <= 1'b1;
   end

   assign o_full             = full | ~normal;
   assign o_empty            = empty;
   assign o_redirect_valid   = ~normal;
   assign o_redirect_pc      = redirect_pc;
   assign o_fb_valid         = fb_valid;
   assign o_fb_pc            = fb_pc;
   assign o_fb_prediction    = fb_pred;
   assign o_fb_outcome       = fb_out;
   assign o_fb_target        = fb_tgt;
   assign o_mispredict_count = mispredict_cnt;
   assign o_error            = error;

endmodule

// File: tb/tb_branch_prediction_checker.sv
// Scoreboard bench for branch_prediction_checker: a queue-based reference
// model predicts each cycle's outcome; a separate monitor pops and compares.
module tb_branch_prediction_checker;

   localparam int DEPTH = 4;
   localparam int AW    = 26;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_push_valid = 1'b0;
   logic [AW-1:0] i_push_pc = '0;
   logic          i_push_prediction = 1'b0;
   logic [AW-1:0] i_push_target = '0;
   logic          o_full, o_empty;
   logic          i_res_valid = 1'b0;
   logic          i_res_outcome = 1'b0;
   logic [AW-1:0] i_res_target = '0;
   logic          o_redirect_valid;
   logic [AW-1:0] o_redirect_pc;
   logic          o_fb_valid;
   logic [AW-1:0] o_fb_pc;
   logic          o_fb_prediction, o_fb_outcome;
   logic [AW-1:0] o_fb_target;
   logic [15:0]   o_mispredict_count;
   logic          o_error;

   branch_prediction_checker #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .i_push_valid(i_push_valid), .i_push_pc(i_push_pc),
      .i_push_prediction(i_push_prediction), .i_push_target(i_push_target),
      .o_full(o_full), .o_empty(o_empty),
      .i_res_valid(i_res_valid), .i_res_outcome(i_res_outcome), .i_res_target(i_res_target),
      .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
      .o_fb_valid(o_fb_valid), .o_fb_pc(o_fb_pc), .o_fb_prediction(o_fb_prediction),
      .o_fb_outcome(o_fb_outcome), .o_fb_target(o_fb_target),
      .o_mispredict_count(o_mispredict_count), .o_error(o_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit [AW-1:0] pc;
      bit          pred;
      bit [AW-1:0] tgt;
   } entry_t;

   typedef struct {
      bit [AW-1:0] pc;
      bit          pred;
      bit          out;
      bit [AW-1:0] tgt;
   } fb_t;

   typedef struct {
      bit          fb_v;
      bit          rd_v;
      bit          empty;
      bit          full;
      bit          err;
      bit [15:0]   cnt;
      bit [AW-1:0] rdpc;
      bit          rst_chk;
   } status_t;

   // Reference model state
   entry_t      mq[$];
   bit          m_redir = 1'b0;
   bit          m_err   = 1'b0;
   bit [15:0]   m_cnt   = '0;
   bit [AW-1:0] m_rdpc  = '0;

   // Scoreboard queues
   status_t stq[$];
   fb_t     fbq[$];

   int checks   = 0;
   int failures = 0;
   bit release_cnt = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; the model predicts the state after the next edge
   task automatic step(input bit pv, input bit [AW-1:0] ppc, input bit ppred,
                       input bit [AW-1:0] ptgt, input bit rv, input bit rout,
                       input bit [AW-1:0] rtgt, input bit r);
      status_t     s;
      entry_t      e;
      entry_t      ne;
      bit          pok, mis;
      bit [AW-1:0] cp;
      @(negedge clk);
      if (release_cnt) begin
         release dut.mispredict_cnt;
         release_cnt = 1'b0;
      end
      rst = r;
      i_push_valid = pv; i_push_pc = ppc; i_push_prediction = ppred; i_push_target = ptgt;
      i_res_valid = rv; i_res_outcome = rout; i_res_target = rtgt;
      s = '{default: '0};
      if (r) begin
         mq.delete();
         m_redir = 1'b0; m_err = 1'b0; m_cnt = '0; m_rdpc = '0;
      end else if (m_redir) begin
         m_redir = 1'b0;
      end else begin
         pok = pv && ((mq.size() < DEPTH) || rv);
         if (pv && mq.size() == DEPTH && !rv) m_err = 1'b1;
         if (rv && mq.size() == 0) m_err = 1'b1;
         if (rv && mq.size() != 0) begin
            e = mq.pop_front();
            s.fb_v = 1'b1;
            fbq.push_back('{pc: e.pc, pred: e.pred, out: rout, tgt: rtgt});
            mis = (rout != e.pred) || (rout && e.pred && rtgt != e.tgt);
            if (mis) begin
               mq.delete();
               pok = 1'b0;
               m_redir = 1'b1;
               cp = e.pc + 26'd8;
               m_rdpc = rout ? rtgt : cp;
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
         end
         if (pok) begin
            ne.pc = ppc; ne.pred = ppred; ne.tgt = ptgt;
            mq.push_back(ne);
         end
      end
      s.rd_v    = m_redir;
      s.empty   = (mq.size() == 0);
      s.full    = m_redir || (mq.size() == DEPTH);
      s.err     = m_err;
      s.cnt     = m_cnt;
      s.rdpc    = m_rdpc;
      s.rst_chk = r;
      stq.push_back(s);
   endtask

   task automatic idle();
      step(0, '0, 0, '0, 0, 0, '0, 0);
   endtask
   task automatic do_rst();
      step(0, '0, 0, '0, 0, 0, '0, 1);
   endtask
   task automatic push(input bit [AW-1:0] pc, input bit pred, input bit [AW-1:0] tgt);
      step(1, pc, pred, tgt, 0, 0, '0, 0);
   endtask
   task automatic resolve(input bit out, input bit [AW-1:0] tgt);
      step(0, '0, 0, '0, 1, out, tgt, 0);
   endtask

   // Monitor: compares the DUT after each edge against the queued expectations
   status_t ms;
   fb_t     mf;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (stq.size() != 0) begin
            ms = stq.pop_front();
            chk("fb_valid", 32'(o_fb_valid), 32'(ms.fb_v));
            if (o_fb_valid) begin
               chk("fb_expected", 32'(fbq.size() != 0), 32'd1);
               if (fbq.size() != 0) begin
                  mf = fbq.pop_front();
                  chk("fb_pc", 32'(o_fb_pc), 32'(mf.pc));
                  chk("fb_prediction", 32'(o_fb_prediction), 32'(mf.pred));
                  chk("fb_outcome", 32'(o_fb_outcome), 32'(mf.out));
                  chk("fb_target", 32'(o_fb_target), 32'(mf.tgt));
               end
            end
            chk("redirect_valid", 32'(o_redirect_valid), 32'(ms.rd_v));
            chk("redirect_pc", 32'(o_redirect_pc), 32'(ms.rdpc));
            chk("empty", 32'(o_empty), 32'(ms.empty));
            chk("full", 32'(o_full), 32'(ms.full));
            chk("error", 32'(o_error), 32'(ms.err));
            chk("mispredict_count", 32'(o_mispredict_count), 32'(ms.cnt));
            if (ms.rst_chk) begin
               chk("rst_fb_pc", 32'(o_fb_pc), 32'd0);
               chk("rst_fb_prediction", 32'(o_fb_prediction), 32'd0);
               chk("rst_fb_outcome", 32'(o_fb_outcome), 32'd0);
               chk("rst_fb_target", 32'(o_fb_target), 32'd0);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Stimulus
   initial begin
      do_rst();
      do_rst();

      // Correct not-taken prediction
      push(26'h100, 0, '0);
      resolve(0, 26'h104);
      idle();

      // Taken outcome on not-taken prediction flushes the younger 0x208
      push(26'h200, 0, '0);
      push(26'h208, 0, '0);
      resolve(1, 26'h400);
      idle();
      idle();

      // Wrong target, then wrong direction on a taken prediction
      push(26'h300, 1, 26'h500);
      resolve(1, 26'h540);
      idle();
      push(26'h300, 1, 26'h500);
      resolve(0, 26'h0);
      idle();

      // Correct taken prediction, and delay-slot PC wrapping past the top
      push(26'h380, 1, 26'h600);
      resolve(1, 26'h600);
      push(26'h3FFFFFC, 1, 26'h10);
      resolve(0, 26'h0);
      idle();

      // Push and resolution during REDIRECT are ignored without error
      push(26'h440, 0, '0);
      resolve(1, 26'h480);
      step(1, 26'h448, 0, '0, 1, 0, '0, 0);
      idle();

      // Resolution against an empty queue sets a sticky error
      resolve(0, '0);
      idle();
      push(26'h500, 0, '0);
      resolve(0, '0);
      idle();

      // Push into an empty queue with a same-cycle resolution
      do_rst();
      step(1, 26'h520, 0, '0, 1, 0, '0, 0);
      resolve(0, '0);
      idle();

      // Fill, overflow, then sustained push+pop while full
      do_rst();
      for (int i = 0; i < DEPTH; i++) push(26'h1000 + 26'(8 * i), 0, '0);
      push(26'h1100, 0, '0);
      for (int i = 0; i < 10; i++) step(1, 26'h2000 + 26'(8 * i), 0, '0, 1, 0, '0, 0);
      for (int i = 0; i < DEPTH; i++) resolve(0, '0);
      idle();

      // Reset during the REDIRECT cycle
      do_rst();
      push(26'h600, 0, '0);
      push(26'h608, 0, '0);
      resolve(1, 26'h700);
      step(1, 26'h610, 0, '0, 1, 1, 26'h700, 1);
      idle();
      idle();

      // Counter saturation from a preset near the top
      do_rst();
      idle();
      force dut.mispredict_cnt = 16'hFFFE;
      m_cnt = 16'hFFFE;
      stq[$].cnt = 16'hFFFE;
      release_cnt = 1'b1;
      push(26'h700, 0, '0);
      resolve(1, 26'h800);
      idle();
      push(26'h710, 0, '0);
      resolve(1, 26'h900);
      idle();
      push(26'h720, 1, 26'h40);
      resolve(0, '0);
      idle();

      // Randomised traffic
      do_rst();
      for (int i = 0; i < 600; i++) begin
         bit [AW-1:0] tset [4];
         tset[0] = 26'h40; tset[1] = 26'h80; tset[2] = 26'h3FFFFC0; tset[3] = 26'h1234;
         step($urandom_range(0, 1) == 1,
              26'($urandom) & 26'h3FFFFFC,
              $urandom_range(0, 1) == 1,
              tset[$urandom_range(0, 3)],
              $urandom_range(0, 9) < 4,
              $urandom_range(0, 1) == 1,
              tset[$urandom_range(0, 3)],
              $urandom_range(0, 149) == 0);
      end
      idle();
      idle();

      @(posedge clk);
      #2;
      @(posedge clk);
      #2;
      chk("status_drained", 32'(stq.size()), 32'd0);
      chk("feedback_drained", 32'(fbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_prediction_checker.md
BRANCH_PREDICTION_CHECKER -- requirements
Module: branch_prediction_checker

Interface
REQ-001 Parameter DEPTH, default 4, in-flight prediction queue entries; power of two, at least 2.
REQ-002 Parameter ADDR_WIDTH, default 26, PC/target width.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 i_push_valid  in  1  fetch issued a prediction this cycle.
REQ-006 i_push_pc  in  ADDR_WIDTH  PC of the predicted instruction.
REQ-007 i_push_prediction  in  1  predicted outcome (1 = TAKEN, 0 = NOT_TAKEN).
REQ-008 i_push_target  in  ADDR_WIDTH  predicted target; meaningful only when prediction = TAKEN.
REQ-009 o_full  out  1  queue cannot accept a push this cycle.
REQ-010 o_empty  out  1  queue holds no entries.
REQ-011 i_res_valid  in  1  decode resolved the oldest outstanding prediction.
REQ-012 i_res_outcome  in  1  actual outcome.
REQ-013 i_res_target  in  ADDR_WIDTH  actual branch target.
REQ-014 o_redirect_valid  out  1  one-cycle fetch redirect pulse.
REQ-015 o_redirect_pc  out  ADDR_WIDTH  corrected fetch PC.
REQ-016 o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome, o_fb_target  out  1/ADDR_WIDTH/1/1/ADDR_WIDTH  predictor/BTB training feedback.
REQ-017 o_mispredict_count  out  16  saturating mispredict count.
REQ-018 o_error  out  1  sticky protocol error flag.

Function
REQ-019 Circular FIFO of DEPTH entries {pc, prediction, target}; write and read pointers are log2(DEPTH)+1 bits wide; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-020 In NORMAL, push is accepted when i_push_valid and (~full, or i_res_valid with queue full); a push while full without a same-cycle pop is dropped and sets o_error.
REQ-021 Resolution in NORMAL with the queue non-empty pops the head entry; with the queue empty (including the same cycle as a push into an empty queue), the resolution is ignored and sets o_error.
REQ-022 Mispredict = (outcome != prediction) or (both TAKEN and i_res_target != entry target).
REQ-023 Corrected PC = i_res_target if outcome TAKEN, else entry pc + 8 (delay slot); addition modulo 2^ADDR_WIDTH.
REQ-024 Every pop drives o_fb_valid high the following cycle, with o_fb_pc = entry pc, o_fb_prediction = entry prediction, o_fb_outcome = i_res_outcome, o_fb_target = i_res_target; otherwise o_fb_valid = 0.
REQ-025 FSM states NORMAL and REDIRECT: NORMAL -> REDIRECT on a pop that mispredicts; REDIRECT -> NORMAL unconditionally after one cycle.
REQ-026 On a mispredicting pop, both pointers reset to 0 at the same edge, flushing all younger entries; a same-cycle push is discarded.
REQ-027 In REDIRECT: o_redirect_valid = 1, o_redirect_pc = the registered corrected PC, o_full = 1; pushes and resolutions are ignored and do not set o_error.
REQ-028 o_redirect_valid = 0 in NORMAL; o_redirect_pc holds its last value.
REQ-029 o_mispredict_count increments by 1 per mispredicting pop and saturates at 0xFFFF.
REQ-030 o_error, once set, stays high until rst.
REQ-031 Latency: resolution to feedback and to redirect is 1 cycle; push to visible (o_empty = 0) is 1 cycle.

Reset
REQ-032 While rst = 1 at posedge: pointers = 0, state = NORMAL, o_empty = 1, o_full = 0, o_redirect_valid = 0, o_redirect_pc = 0, o_fb_valid = 0, feedback data = 0, o_mispredict_count = 0, o_error = 0.
REQ-033 rst asserted mid-operation (including during REDIRECT) discards all entries and in-flight pulses at that edge; no feedback or redirect emerges afterwards.

Verification
REQ-034 Push pc=0x100 pred=NOT_TAKEN; resolve outcome NOT_TAKEN -> next cycle o_fb_valid=1, o_fb_pc=0x100, o_redirect_valid=0, count=0.
REQ-035 Push pc=0x200 pred=NOT_TAKEN, then pc=0x208; resolve TAKEN target=0x400 -> redirect pulse 1 cycle, o_redirect_pc=0x400, o_empty=1, count=1, 0x208 never fed back.
REQ-036 Push pc=0x300 TAKEN target=0x500; resolve TAKEN target=0x540 -> redirect to 0x540; resolve NOT_TAKEN on a TAKEN entry at pc=0x300 -> redirect to 0x308.
REQ-037 Fill DEPTH=4 -> o_full=1; 5th push alone -> o_error=1; with simultaneous push+pop while full, occupancy stays 4 and pointers wrap correctly across 10 iterations.
REQ-038 Resolve with queue empty -> o_error=1, stays set until rst; count preset at 0xFFFF plus one more mispredict -> stays 0xFFFF.
REQ-039 Assert rst during the REDIRECT cycle -> next cycle o_redirect_valid=0, o_empty=1, all outputs at reset values.
